// File: rtl/rv_pkg.sv
// Shared definitions for the RV32M execute-stage helpers: divider op codes,
// divider FSM state encoding and the default datapath width.
package rv_pkg;

  localparam int XLEN_DEFAULT = 32;

  localparam logic [1:0] DIV_OP_DIV  = 2'b00;
  localparam logic [1:0] DIV_OP_DIVU = 2'b01;
  localparam logic [1:0] DIV_OP_REM  = 2'b10;
  localparam logic [1:0] DIV_OP_REMU = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/prefix_sub33.sv
// Combinational parallel-prefix (Kogge-Stone) subtractor: diff = a + ~b + 1.
// The carry-in of 1 is folded into the bit-0 generate term.
module prefix_sub33 #(
  parameter int W = 33
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] diff
);

  logic [W-1:0] nb;
  logic [W-1:0] p0;
  logic [W-1:0] g;
  logic [W-1:0] p;
  logic [W-1:0] g_n;
  logic [W-1:0] p_n;

  always_comb begin
    nb   = ~b;
    p0   = a ^ nb;
    g    = a & nb;
    g[0] = a[0] | nb[0];
    p    = p0;
    g_n  = g;
    p_n  = p;
    for (int d = 1; d < W; d = d * 2) begin
      g_n = g;
      p_n = p;
      for (int i = d; i < W; i++) begin
        g_n[i] = g[i] | (p[i] & g[i-d]);
        p_n[i] = p[i] & p[i-d];
      end
      g = g_n;
      p = p_n;
    end
    diff = p0 ^ {g[W-2:0], 1'b1};
  end

endmodule

// File: rtl/iter_divider.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU: one trial subtraction per
// cycle on operand magnitudes, followed by a single sign fix-up cycle.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | XLEN shift/subtract iterations, counter 0..XLEN-1
// FIX   | apply quotient/remainder signs, select the result
// DONE  | result valid, held until out_ready
module iter_divider
  import rv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  div_state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]  r_q, r_d;
  logic [XLEN-1:0]  q_q, q_d;
  logic [XLEN-1:0]  dvsr_q, dvsr_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic             is_rem_q, is_rem_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic            accept;
  logic            div_zero;
  logic            sgn_ovf;
  logic            sign_a;
  logic            sign_b;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quo_fixed;
  logic [XLEN-1:0] rem_fixed;

  assign accept   = (state_q == IDLE) && in_valid && !flush;
  assign div_zero = (divisor == '0);
  assign sgn_ovf  = op_is_signed(op) && (dividend == {1'b1, {(XLEN-1){1'b0}}}) &&
                    (divisor == '1);
  assign sign_a   = op_is_signed(op) && dividend[XLEN-1];
  assign sign_b   = op_is_signed(op) && divisor[XLEN-1];

  prefix_sub33 #(.W(XLEN + 1)) u_trial_sub (
    .a    ({r_q, q_q[XLEN-1]}),
    .b    ({1'b0, dvsr_q}),
    .diff (trial)
  );

  assign quo_fixed = neg_quo_q ? (~q_q + XLEN'(1)) : q_q;
  assign rem_fixed = neg_rem_q ? (~r_q + XLEN'(1)) : r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (in_valid) state_d = (div_zero || sgn_ovf) ? DONE : CALC;
        CALC: if (cnt_q == CNT_LAST) state_d = FIX;
        FIX:  state_d = DONE;
        DONE: if (out_ready) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == CALC) || (state_q == FIX);
    result    = result_q;
  end

  always_comb begin
    cnt_d     = cnt_q;
    r_d       = r_q;
    q_d       = q_q;
    dvsr_d    = dvsr_q;
    result_d  = result_q;
    is_rem_d  = is_rem_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    if (accept) begin
      is_rem_d  = op_is_rem(op);
      neg_quo_d = sign_a ^ sign_b;
      neg_rem_d = sign_a;
      q_d       = sign_a ? (~dividend + XLEN'(1)) : dividend;
      dvsr_d    = sign_b ? (~divisor + XLEN'(1)) : divisor;
      r_d       = '0;
      cnt_d     = '0;
      if (div_zero) begin
        result_d = op_is_rem(op) ? dividend : '1;
      end else if (sgn_ovf) begin
        result_d = op_is_rem(op) ? '0 : {1'b1, {(XLEN-1){1'b0}}};
      end
    end else if (!flush && state_q == CALC) begin
      // A clear borrow bit means the divisor fit: keep the difference, shift in 1.
      if (!trial[XLEN]) begin
        r_d = trial[XLEN-1:0];
        q_d = {q_q[XLEN-2:0], 1'b1};
      end else begin
        r_d = {r_q[XLEN-2:0], q_q[XLEN-1]};
        q_d = {q_q[XLEN-2:0], 1'b0};
      end
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!flush && state_q == FIX) begin
      result_d = is_rem_q ? rem_fixed : quo_fixed;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dvsr_q    <= '0;
      result_q  <= '0;
      is_rem_q  <= 1'b0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      q_q       <= q_d;
      dvsr_q    <= dvsr_d;
      result_q  <= result_d;
      is_rem_q  <= is_rem_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: directed corner cases plus randomized
// operations compared against a plain-arithmetic RV32M division model.
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks = 0;
  int errors = 0;

  iter_divider #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // RV32M semantics from plain integer arithmetic in a 64-bit domain.
  function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
    if (o[0] == 1'b0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return o[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return o[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b);
    if (b == 32'd0) return 0;
    if (o[0] == 1'b0 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return 33;
  endfunction

  // Called one time unit after a rising edge while idle; returns after out_valid.
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    op = o; dividend = a; divisor = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom; divisor = $urandom;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    op = 2'b00; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset: in_ready/out_valid/busy=%b result=%h, want 100 and 0",
               {in_ready, out_valid, busy}, result);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [31:0] res;
    int lat;
    logic [1:0]  ops [2]   = '{2'b00, 2'b10};
    logic [31:0] exps [2]  = '{32'd14, 32'd2};
    for (int i = 0; i < 2; i++) begin
      do_op(ops[i], 32'd100, 32'd7, res, lat);
      checks++;
      if (res !== exps[i] || lat != 33) begin
        errors++;
        $display("FAIL basic op%0d: result=%h latency=%0d, want %h latency 33",
                 ops[i], res, lat, exps[i]);
      end
      handoff();
    end
  endtask

  task automatic test_signed();
    logic [31:0] res;
    int lat;
    logic [1:0]  ops [4] = '{2'b00, 2'b10, 2'b01, 2'b11};
    logic [31:0] as  [4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd7};
    logic [31:0] bs  [4] = '{32'd2, 32'd2, 32'd1, 32'hFFFF_FFFF};
    logic [31:0] ex  [4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7};
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], bs[i], res, lat);
      checks++;
      if (res !== ex[i] || lat != 33) begin
        errors++;
        $display("FAIL signed case%0d: result=%h latency=%0d, want %h latency 33",
                 i, res, lat, ex[i]);
      end
      handoff();
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] res;
    int lat;
    logic [1:0]  ops [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] as  [4] = '{32'd5, 32'd5, 32'd5, 32'h8000_0001};
    logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'h8000_0001};
    for (int i = 0; i < 4; i++) begin
      do_op(ops[i], as[i], 32'd0, res, lat);
      checks++;
      if (res !== ex[i] || lat != 0) begin
        errors++;
        $display("FAIL div_zero case%0d: result=%h latency=%0d, want %h latency 0",
                 i, res, lat, ex[i]);
      end
      handoff();
    end
  endtask

  task automatic test_overflow();
    logic [31:0] res;
    int lat;
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    checks++;
    if (res !== 32'h8000_0000 || lat != 0) begin
      errors++;
      $display("FAIL ovf_div: result=%h latency=%0d, want 80000000 latency 0", res, lat);
    end
    handoff();
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    checks++;
    if (res !== 32'd0 || lat != 0) begin
      errors++;
      $display("FAIL ovf_rem: result=%h latency=%0d, want 0 latency 0", res, lat);
    end
    handoff();
    do_op(2'b00, 32'h8000_0000, 32'd1, res, lat);
    checks++;
    if (res !== 32'h8000_0000 || lat != 33) begin
      errors++;
      $display("FAIL min_by_one: result=%h latency=%0d, want 80000000 latency 33", res, lat);
    end
    handoff();
  endtask

  task automatic test_back_to_back();
    logic [31:0] res;
    logic [31:0] a, b;
    logic [1:0]  o;
    int lat;
    int bad;
    do_op(2'b01, 32'd1000, 32'd33, res, lat);
    // Stall the consumer while a competing request sits on the inputs.
    op = 2'b00; dividend = 32'd81; divisor = 32'd9; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 32'd30) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold: %0d unstable cycles, last out_valid=%b in_ready=%b result=%h, want 1 0 0000001e",
               bad, out_valid, in_ready, result);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handoff: in_ready=%b out_valid=%b busy=%b, want 1 0 0",
               in_ready, out_valid, busy);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (result !== 32'd9 || lat != 33) begin
      errors++;
      $display("FAIL b2b_accept: result=%h latency=%0d, want 00000009 latency 33", result, lat);
    end
    handoff();

    for (int n = 0; n < 1000; n++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        4: a = 32'h8000_0000;
        5: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        6: b = b >> $urandom_range(0, 31);
        default: ;
      endcase
      do_op(o, a, b, res, lat);
      checks++;
      if (res !== ref_div(o, a, b) || lat != ref_lat(o, a, b)) begin
        errors++;
        $display("FAIL random%0d op%0d %h/%h: result=%h latency=%0d, want %h latency %0d",
                 n, o, a, b, res, lat, ref_div(o, a, b), ref_lat(o, a, b));
      end
      handoff();
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat;
    int rises;
    op = 2'b00; dividend = 32'd12345; divisor = 32'd11; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc: in_ready=%b busy=%b out_valid=%b, want 1 0 0",
               in_ready, busy, out_valid);
    end
    rises = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) rises++;
    end
    checks++;
    if (rises != 0) begin
      errors++;
      $display("FAIL flush_discard: out_valid high %0d cycles, want 0", rises);
    end
    op = 2'b01; dividend = 32'd9; divisor = 32'd3; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle: in_ready=%b busy=%b out_valid=%b, want 1 0 0",
               in_ready, busy, out_valid);
    end
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, res, lat);
    checks++;
    if (res !== 32'hFFFF_FFFE || lat != 33) begin
      errors++;
      $display("FAIL after_flush: result=%h latency=%0d, want fffffffe latency 33", res, lat);
    end
    handoff();
  endtask

  task automatic test_reset_at_fix();
    op = 2'b01; dividend = 32'd500; divisor = 32'd4; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (32) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b1 || result === 32'd0) begin
      errors++;
      $display("FAIL pre_reset: busy=%b result=%h, want busy 1 and nonzero held result",
               busy, result);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_at_fix: in_ready/out_valid/busy=%b result=%h, want 100 and 0",
               {in_ready, out_valid, busy}, result);
    end
    repeat (40) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: out_valid=%b, want 0", out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_flush();
    test_reset_at_fix();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
